// File: rtl/sr_ff.sv
// Bank of independent clocked SR flip-flops with complementary outputs.
// Each lane owns one state bit; q_bar is derived combinationally from it.

module sr_ff_bit #(
  parameter int INVALID_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic illegal
);

  logic d;

  // s=r=1 resolution; unknown modes fall back to hold so q never goes X
  always_comb begin
    d = q;
    case ({s, r})
      2'b10: d = 1'b1;
      2'b01: d = 1'b0;
      2'b11: begin
        case (INVALID_MODE)
          1:       d = 1'b1;
          2:       d = 1'b0;
          3:       d = ~q;
          default: d = q;
        endcase
      end
      default: d = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= 1'b0;
      illegal <= 1'b0;
    end else begin
      q       <= d;
      illegal <= s & r;
    end
  end

endmodule

module sr_ff #(
  parameter int WIDTH        = 1,
  parameter int INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] illegal
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_ff_bit #(.INVALID_MODE(INVALID_MODE)) u_bit (
      .clk     (clk),
      .rst     (rst),
      .s       (s[i]),
      .r       (r[i]),
      .q       (q[i]),
      .illegal (illegal[i])
    );
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: four 1-bit instances (modes 0..3) and three
// 4-bit instances (modes 0, 3, 5) against a rule-level reference model.

module tb_sr_ff;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0]      s1 = '0, r1 = '0;
  logic [3:0]      q1, qb1, il1;
  logic [2:0][3:0] s4 = '0, r4 = '0;
  logic [2:0][3:0] q4, qb4, il4;

  logic [3:0]      mq1, mi1;
  logic [2:0][3:0] mq4, mi4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_w1
    sr_ff #(.WIDTH(1), .INVALID_MODE(k)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .s       (s1[k]),
      .r       (r1[k]),
      .q       (q1[k]),
      .q_bar   (qb1[k]),
      .illegal (il1[k])
    );
  end

  for (genvar j = 0; j < 3; j++) begin : g_w4
    sr_ff #(.WIDTH(4), .INVALID_MODE(j == 0 ? 0 : (j == 1 ? 3 : 5))) u_dut (
      .clk     (clk),
      .rst     (rst),
      .s       (s4[j]),
      .r       (r4[j]),
      .q       (q4[j]),
      .q_bar   (qb4[j]),
      .illegal (il4[j])
    );
  end

  function automatic int mode4(int j);
    return (j == 0) ? 0 : ((j == 1) ? 3 : 5);
  endfunction

  // Truth-table rules of an SR flip-flop plus the s=r=1 policy
  function automatic logic ref_bit(int mode, logic s, logic r, logic q);
    if (!s && !r) return q;
    if (s && !r)  return 1'b1;
    if (!s && r)  return 1'b0;
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    if (mode == 3) return !q;
    return q;
  endfunction

  task automatic model_reset();
    mq1 = '0; mi1 = '0; mq4 = '0; mi4 = '0;
  endtask

  task automatic model_edge();
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        mi1[k] = s1[k] & r1[k];
        mq1[k] = ref_bit(k, s1[k], r1[k], mq1[k]);
      end
      for (int j = 0; j < 3; j++)
        for (int b = 0; b < 4; b++) begin
          mi4[j][b] = s4[j][b] & r4[j][b];
          mq4[j][b] = ref_bit(mode4(j), s4[j][b], r4[j][b], mq4[j][b]);
        end
    end
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".q1"},  q1,  mq1);
    chk({tag, ".qb1"}, qb1, ~mq1);
    chk({tag, ".il1"}, il1, mi1);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s.q4[%0d]", tag, j),  q4[j],  mq4[j]);
      chk($sformatf("%s.qb4[%0d]", tag, j), qb4[j], ~mq4[j]);
      chk($sformatf("%s.il4[%0d]", tag, j), il4[j], mi4[j]);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic async_rst(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
  endtask

  task automatic release_rst(string tag);
    rst = 1'b0;
    #1 check_all(tag);
  endtask

  initial begin
    model_reset();
    #1 async_rst("por");

    // clock edges ignored while reset is held, even with s=1
    s1 = '1; r1 = '0;
    tick("rst_hold1");
    tick("rst_hold2");
    chk("rst_hold_q", q1, 4'b0000);
    #3 release_rst("release_quiet");

    s4 = {3{4'b0101}}; r4 = {3{4'b0011}};
    tick("set");
    chk("set_q", q1, 4'b1111);
    chk("set_qb", qb1, 4'b0000);
    chk("w4_q_m0", q4[0], 4'b0100);
    chk("w4_qb_m0", qb4[0], 4'b1011);
    chk("w4_il_m0", il4[0], 4'b0001);
    chk("w4_q_m3", q4[1], 4'b0101);
    chk("w4_q_m5", q4[2], 4'b0100);
    s4 = '0; r4 = '0;

    s1 = '0; r1 = '0; tick("hold");
    chk("hold_q", q1, 4'b1111);
    s1 = '0; r1 = '1; tick("clear");
    chk("clear_q", q1, 4'b0000);
    s1 = '1; r1 = '0; tick("set2");

    // reset wins over a pending set, asynchronously
    #2 async_rst("rst_over_set");
    chk("rst_over_set_q", q1, 4'b0000);
    tick("rst_over_set_e1");
    tick("rst_over_set_e2");
    #3 release_rst("release_mid");
    tick("set_after_release");
    chk("set_after_release_q", q1, 4'b1111);

    // s=r=1 from q=1: modes hold/set/reset/toggle
    s1 = '1; r1 = '1;
    tick("inv1");
    chk("inv1_q", q1, 4'b0011);
    chk("inv1_il", il1, 4'b1111);
    tick("inv2");
    chk("inv2_q", q1, 4'b1011);
    s1 = '0; r1 = '0; tick("inv_off");
    chk("inv_off_il", il1, 4'b0000);
    s1 = '1; r1 = '1; tick("inv3");
    #2 async_rst("rst_during_inv");
    chk("rst_during_inv_il", il1, 4'b0000);
    tick("rst_during_inv_e");
    #3 release_rst("release_inv");

    // s=r=1 from q=0: mode 3 alternates 1,0,1
    tick("tog1");
    chk("tog1_q", q1, 4'b1010);
    tick("tog2");
    chk("tog2_q", q1, 4'b0010);
    tick("tog3");
    chk("tog3_q", q1, 4'b1010);

    // randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 300; n++) begin
      #1;
      s1 = 4'($urandom); r1 = 4'($urandom);
      for (int j = 0; j < 3; j++) begin
        s4[j] = 4'($urandom); r4[j] = 4'($urandom);
      end
      if (rst && ($urandom_range(0, 2) == 0))
        #1 release_rst("rnd_release");
      else if (!rst && ($urandom_range(0, 19) == 0))
        #1 async_rst("rnd_rst");
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
